// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared encodings, FSM state and request legality helper
package data_mem_responder_pkg;

   localparam int CNT_W = 4;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   localparam logic [1:0] ST_SB = 2'b00;
   localparam logic [1:0] ST_SH = 2'b01;
   localparam logic [1:0] ST_SW = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Legal means exactly one of read/write, a defined code, and natural alignment.
   function automatic logic req_legal(input logic       rd_en,
                                      input logic [2:0] ld_f3,
                                      input logic       wr_en,
                                      input logic [1:0] st_w,
                                      input logic [1:0] lane);
      logic ok;
      ok = 1'b0;
      if (rd_en && !wr_en) begin
         case (ld_f3)
            LD_LB, LD_LBU: ok = 1'b1;
            LD_LH, LD_LHU: ok = !lane[0];
            LD_LW:         ok = (lane == 2'b00);
            default:       ok = 1'b0;
         endcase
      end else if (wr_en && !rd_en) begin
         case (st_w)
            ST_SB:   ok = 1'b1;
            ST_SH:   ok = !lane[0];
            ST_SW:   ok = (lane == 2'b00);
            default: ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/load_align_extend.sv
// rtl/load_align_extend.sv - selects the addressed load lane and sign/zero extends it
module load_align_extend
   import data_mem_responder_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  lane_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[7:0];
      case (lane_i)
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         2'd3:    byte_sel = word_i[31:24];
         default: byte_sel = word_i[7:0];
      endcase
      half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

      data_o = 32'h0;
      case (funct3_i)
         LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
         LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
         LD_LW:   data_o = word_i;
         LD_LBU:  data_o = {24'h0, byte_sel};
         LD_LHU:  data_o = {16'h0, half_sel};
         default: data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data memory with busywait handshake,
// byte/halfword/word access and illegal-request error pulse
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int MEM_DEPTH_WORDS = 256,
   parameter int ACCESS_LATENCY  = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [3:0]  DATA_MEM_READ,
   input  logic [2:0]  DATA_MEM_WRITE,
   input  logic [31:0] ADDRESS,
   input  logic [31:0] WRITE_DATA,
   output logic [31:0] READ_DATA,
   output logic        BUSYWAIT,
   output logic        ERROR
);

   localparam int AW = $clog2(MEM_DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_LATENCY - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [AW+1:0]    addr_q;
   logic [31:0]      wdata_q;
   logic [31:0]      read_data_q;
   logic [2:0]       ld_f3_q;
   logic [1:0]       st_w_q;
   logic             is_wr_q;
   logic             error_q;
   logic [31:0]      mem_q [MEM_DEPTH_WORDS];

   logic          rd_en, wr_en, req, legal, last_beat, mem_we;
   logic [3:0]    be_mask;
   logic [31:0]   wr_lanes;
   logic [31:0]   load_d;
   logic [AW-1:0] idx;
   logic          unused_addr_hi;

   assign rd_en     = DATA_MEM_READ[3];
   assign wr_en     = DATA_MEM_WRITE[2];
   assign req       = rd_en | wr_en;
   assign legal     = req_legal(rd_en, DATA_MEM_READ[2:0], wr_en, DATA_MEM_WRITE[1:0], ADDRESS[1:0]);
   assign idx       = addr_q[AW+1:2];
   assign last_beat = (state_q == ACCESS) && (cnt_q == '0);
   assign mem_we    = last_beat && is_wr_q && !RESET;

   // Upper address bits are deliberately dropped so accesses wrap modulo depth.
   assign unused_addr_hi = ^ADDRESS[31:AW+2];

   assign BUSYWAIT  = !RESET && (((state_q == IDLE) && req) || (state_q == ACCESS));
   assign READ_DATA = read_data_q;
   assign ERROR     = error_q;

   always_comb begin
      be_mask  = 4'b0000;
      wr_lanes = wdata_q;
      case (st_w_q)
         ST_SB: begin
            be_mask  = 4'b0001 << addr_q[1:0];
            wr_lanes = {4{wdata_q[7:0]}};
         end
         ST_SH: begin
            be_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{wdata_q[15:0]}};
         end
         ST_SW:   be_mask = 4'b1111;
         default: be_mask = 4'b0000;
      endcase
   end

   load_align_extend u_load_align_extend (
      .word_i   (mem_q[idx]),
      .funct3_i (ld_f3_q),
      .lane_i   (addr_q[1:0]),
      .data_o   (load_d)
   );

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be_mask[i]) mem_q[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ld_f3_q     <= '0;
         st_w_q      <= '0;
         is_wr_q     <= 1'b0;
         read_data_q <= '0;
         error_q     <= 1'b0;
      end else begin
         error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req) begin
                  if (legal) begin
                     addr_q  <= ADDRESS[AW+1:0];
                     wdata_q <= WRITE_DATA;
                     ld_f3_q <= DATA_MEM_READ[2:0];
                     st_w_q  <= DATA_MEM_WRITE[1:0];
                     is_wr_q <= wr_en;
                     cnt_q   <= CNT_INIT;
                     state_q <= ACCESS;
                  end else begin
                     read_data_q <= '0;
                     error_q     <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            ACCESS: begin
               if (cnt_q == '0) begin
                  if (!is_wr_q) read_data_q <= load_d;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed vector table, reset abort sequence and
// randomized requests checked against a byte-array reference model
module tb_data_mem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 4;
   localparam int BYTES = DEPTH * 4;
   localparam int NVEC  = 24;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [3:0]  DATA_MEM_READ;
   logic [2:0]  DATA_MEM_WRITE;
   logic [31:0] ADDRESS;
   logic [31:0] WRITE_DATA;
   logic [31:0] READ_DATA;
   logic        BUSYWAIT;
   logic        ERROR;

   always #5 CLK = ~CLK;

   data_mem_responder #(.MEM_DEPTH_WORDS(DEPTH), .ACCESS_LATENCY(LAT)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .DATA_MEM_READ  (DATA_MEM_READ),
      .DATA_MEM_WRITE (DATA_MEM_WRITE),
      .ADDRESS        (ADDRESS),
      .WRITE_DATA     (WRITE_DATA),
      .READ_DATA      (READ_DATA),
      .BUSYWAIT       (BUSYWAIT),
      .ERROR          (ERROR)
   );

   int          n_checks = 0;
   int          n_err    = 0;
   logic [7:0]  ref_mem [BYTES];
   logic [31:0] model_rd;

   typedef struct {
      logic [3:0]  rd;
      logic [2:0]  wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Reference: memory is a flat byte array indexed by address modulo its size.
   task automatic model_req(input logic [3:0] rd, input logic [2:0] wr,
                            input logic [31:0] a, input logic [31:0] d,
                            output int e_busy, output logic e_err, output logic [31:0] e_rd);
      int size, base;
      bit legal;
      logic [31:0] v;
      size = 0;
      if (!rd[3] && !wr[2]) begin
         e_busy = 0; e_err = 1'b0; e_rd = model_rd;
         return;
      end
      if (rd[3] && !wr[2]) begin
         case (rd[2:0])
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
         endcase
      end else if (wr[2] && !rd[3]) begin
         case (wr[1:0])
            2'b00:   size = 1;
            2'b01:   size = 2;
            2'b10:   size = 4;
            default: size = 0;
         endcase
      end
      legal = (size != 0) && ((a % size) == 0);
      if (!legal) begin
         model_rd = 32'h0; e_busy = 1; e_err = 1'b1;
      end else begin
         base = int'(a % BYTES);
         if (wr[2]) begin
            for (int i = 0; i < size; i++) ref_mem[base+i] = d[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
            if (!rd[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            model_rd = v;
         end
         e_busy = LAT + 1; e_err = 1'b0;
      end
      e_rd = model_rd;
   endtask

   task automatic run_req(input logic [3:0] rd, input logic [2:0] wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int busy, output logic err, output logic [31:0] rdat,
                          output int stray_err);
      @(negedge CLK);
      DATA_MEM_READ = rd; DATA_MEM_WRITE = wr; ADDRESS = a; WRITE_DATA = d;
      #1;
      busy = 0; stray_err = 0;
      while (BUSYWAIT === 1'b1 && busy < 50) begin
         busy++;
         if (ERROR !== 1'b0) stray_err++;
         @(posedge CLK);
         #1;
         DATA_MEM_READ = 4'h0; DATA_MEM_WRITE = 3'h0;
         @(negedge CLK);
      end
      err  = ERROR;
      rdat = READ_DATA;
      DATA_MEM_READ = 4'h0; DATA_MEM_WRITE = 3'h0;
      @(negedge CLK);
      if (ERROR !== 1'b0) stray_err++;
   endtask

   task automatic do_req(input string name, input logic [3:0] rd, input logic [2:0] wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit use_const, input logic [31:0] c_rd, input logic c_err);
      int e_busy, busy, stray;
      logic e_err, err;
      logic [31:0] e_rd, rdat;
      model_req(rd, wr, a, d, e_busy, e_err, e_rd);
      run_req(rd, wr, a, d, busy, err, rdat, stray);
      check({name, "_busy"}, 32'(busy), 32'(e_busy));
      check({name, "_err"}, {31'h0, err}, {31'h0, e_err});
      check({name, "_rdata"}, rdat, e_rd);
      check({name, "_stray_err"}, 32'(stray), 32'h0);
      if (use_const) begin
         check({name, "_rdata_vec"}, rdat, c_rd);
         check({name, "_busy_vec"}, 32'(busy), c_err ? 32'd1 : 32'(LAT + 1));
         check({name, "_err_vec"}, {31'h0, err}, {31'h0, c_err});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0]  rd;
      logic [2:0]  wr;
      logic [31:0] a;
      int          k;

      vecs[0]  = '{4'b0000, 3'b110, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[1]  = '{4'b1010, 3'b000, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{4'b0000, 3'b110, 32'h20,  32'h000080F0, 32'hDEADBEEF, 1'b0};
      vecs[3]  = '{4'b1000, 3'b000, 32'h20,  32'h0,        32'hFFFFFFF0, 1'b0};
      vecs[4]  = '{4'b1100, 3'b000, 32'h21,  32'h0,        32'h00000080, 1'b0};
      vecs[5]  = '{4'b1001, 3'b000, 32'h20,  32'h0,        32'hFFFF80F0, 1'b0};
      vecs[6]  = '{4'b1101, 3'b000, 32'h20,  32'h0,        32'h000080F0, 1'b0};
      vecs[7]  = '{4'b0000, 3'b110, 32'h30,  32'h11223344, 32'h000080F0, 1'b0};
      vecs[8]  = '{4'b0000, 3'b100, 32'h32,  32'h000000AA, 32'h000080F0, 1'b0};
      vecs[9]  = '{4'b0000, 3'b101, 32'h30,  32'h0000BEEF, 32'h000080F0, 1'b0};
      vecs[10] = '{4'b1010, 3'b000, 32'h30,  32'h0,        32'h11AABEEF, 1'b0};
      vecs[11] = '{4'b0000, 3'b110, 32'h400, 32'h00000077, 32'h11AABEEF, 1'b0};
      vecs[12] = '{4'b1010, 3'b000, 32'h000, 32'h0,        32'h00000077, 1'b0};
      vecs[13] = '{4'b1010, 3'b000, 32'h13,  32'h0,        32'h00000000, 1'b1};
      vecs[14] = '{4'b1010, 3'b000, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      vecs[15] = '{4'b0000, 3'b101, 32'h01,  32'h0000FFFF, 32'h00000000, 1'b1};
      vecs[16] = '{4'b1010, 3'b000, 32'h00,  32'h0,        32'h00000077, 1'b0};
      vecs[17] = '{4'b1011, 3'b000, 32'h10,  32'h0,        32'h00000000, 1'b1};
      vecs[18] = '{4'b1010, 3'b000, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      vecs[19] = '{4'b1010, 3'b110, 32'h10,  32'h0,        32'h00000000, 1'b1};
      vecs[20] = '{4'b1010, 3'b000, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      vecs[21] = '{4'b0000, 3'b100, 32'h13,  32'h0000005A, 32'hDEADBEEF, 1'b0};
      vecs[22] = '{4'b1010, 3'b000, 32'h10,  32'h0,        32'h5AADBEEF, 1'b0};
      vecs[23] = '{4'b0000, 3'b110, 32'h40,  32'h00000005, 32'h5AADBEEF, 1'b0};

      // Reset with a read request pending: BUSYWAIT must stay low.
      RESET = 1'b1;
      DATA_MEM_READ = 4'b1010; DATA_MEM_WRITE = 3'b000; ADDRESS = 32'h0; WRITE_DATA = 32'h0;
      model_rd = 32'h0;
      repeat (2) @(negedge CLK);
      check("reset_busywait", {31'h0, BUSYWAIT}, 32'h0);
      check("reset_read_data", READ_DATA, 32'h0);
      check("reset_error", {31'h0, ERROR}, 32'h0);
      DATA_MEM_READ = 4'h0;
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("idle_no_req_busywait", {31'h0, BUSYWAIT}, 32'h0);

      for (int i = 0; i < NVEC; i++) begin
         do_req($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                1'b1, vecs[i].exp_rd, vecs[i].exp_err);
      end

      // Reset two cycles into the ACCESS phase of SW 0x9 @0x40 must drop the write.
      @(negedge CLK);
      DATA_MEM_READ = 4'h0; DATA_MEM_WRITE = 3'b110; ADDRESS = 32'h40; WRITE_DATA = 32'h9;
      @(posedge CLK);
      #1;
      DATA_MEM_WRITE = 3'h0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b1;
      DATA_MEM_READ = 4'b1010;
      #1;
      check("midreset_busywait", {31'h0, BUSYWAIT}, 32'h0);
      check("midreset_read_data", READ_DATA, 32'h0);
      check("midreset_error", {31'h0, ERROR}, 32'h0);
      repeat (2) @(negedge CLK);
      check("midreset_hold_busywait", {31'h0, BUSYWAIT}, 32'h0);
      check("midreset_hold_read_data", READ_DATA, 32'h0);
      DATA_MEM_READ = 4'h0;
      RESET = 1'b0;
      model_rd = 32'h0;
      do_req("after_reset_lw40", 4'b1010, 3'b000, 32'h40, 32'h0, 1'b1, 32'h00000005, 1'b0);

      // Randomized phase over the first 16 words, with random upper address bits.
      for (int w = 0; w < 16; w++) begin
         do_req($sformatf("init%0d", w), 4'h0, 3'b110, 32'(w * 4), $urandom, 1'b0, 32'h0, 1'b0);
      end
      for (int n = 0; n < 150; n++) begin
         k  = $urandom_range(0, 9);
         a  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         rd = {1'b0, 3'($urandom_range(0, 7))};
         wr = {1'b0, 2'($urandom_range(0, 3))};
         if (k < 4)       rd[3] = 1'b1;
         else if (k < 8)  wr[2] = 1'b1;
         else if (k == 8) begin rd[3] = 1'b1; wr[2] = 1'b1; end
         do_req($sformatf("rnd%0d", n), rd, wr, a, $urandom, 1'b0, 32'h0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
